// File: rtl/ht_head_table.sv
// Head-pointer lookup stage: reads the per-bucket head pointer and forwards the command with it.
// Define HT_HEAD_TABLE_INIT_EN to zero the table with a sweep after reset.
module ht_head_table #(
  parameter int unsigned KEY_WIDTH      = 32,
  parameter int unsigned VALUE_WIDTH    = 32,
  parameter int unsigned BUCKET_WIDTH   = 4,
  parameter int unsigned HEAD_PTR_WIDTH = 8,
  parameter type         ht_opcode_t    = logic [1:0]
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [KEY_WIDTH-1:0]      in_key,
  input  logic [VALUE_WIDTH-1:0]    in_value,
  input  ht_opcode_t                in_opcode,
  input  logic [BUCKET_WIDTH-1:0]   in_bucket,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [KEY_WIDTH-1:0]      out_key,
  output logic [VALUE_WIDTH-1:0]    out_value,
  output ht_opcode_t                out_opcode,
  output logic [BUCKET_WIDTH-1:0]   out_bucket,
  output logic [HEAD_PTR_WIDTH-1:0] out_head_ptr,
  output logic                      out_head_ptr_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      upd_valid,
  input  logic [BUCKET_WIDTH-1:0]   upd_bucket,
  input  logic [HEAD_PTR_WIDTH-1:0] upd_head_ptr,
  input  logic                      upd_head_ptr_val
);

  localparam int unsigned Depth = 1 << BUCKET_WIDTH;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                    state_q;
  logic [BUCKET_WIDTH-1:0]   init_cnt_q;
  logic [HEAD_PTR_WIDTH:0]   mem_q [Depth];
  logic [HEAD_PTR_WIDTH:0]   ram_rd_q;

  logic                      s1_valid_q;
  logic                      s1_fresh_q;
  logic [HEAD_PTR_WIDTH:0]   s1_hold_q;
  logic [KEY_WIDTH-1:0]      s1_key_q;
  logic [VALUE_WIDTH-1:0]    s1_value_q;
  ht_opcode_t                s1_opcode_q;
  logic [BUCKET_WIDTH-1:0]   s1_bucket_q;

  logic                      run;
  logic                      upd_en;
  logic                      acc;
  logic                      out_adv;
  logic                      wr_en;
  logic [BUCKET_WIDTH-1:0]   wr_addr;
  logic [HEAD_PTR_WIDTH:0]   wr_data;
  logic [HEAD_PTR_WIDTH:0]   s1_entry;
  logic [HEAD_PTR_WIDTH:0]   s1_patched;

  always_comb begin
    run      = (state_q == StRun) && !rst_i;
    upd_en   = upd_valid && (state_q == StRun);
    out_adv  = !out_valid || out_ready;
    in_ready = run && !(s1_valid_q && !out_adv);
    acc      = in_valid && in_ready;

    wr_en    = upd_en;
    wr_addr  = upd_bucket;
    wr_data  = {upd_head_ptr_val, upd_head_ptr};
    if (state_q == StInit) begin
      wr_en   = 1'b1;
      wr_addr = init_cnt_q;
      wr_data = '0;
    end

    // S1 data lives in the RAM output register only on its first cycle, then in the hold copy.
    s1_entry   = s1_fresh_q ? ram_rd_q : s1_hold_q;
    s1_patched = s1_entry;
    if (upd_en && (upd_bucket == s1_bucket_q)) begin
      s1_patched = {upd_head_ptr_val, upd_head_ptr};
    end
  end

  // Table storage with write-first bypass on the read port; intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    ram_rd_q <= (wr_en && (wr_addr == in_bucket)) ? wr_data : mem_q[in_bucket];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
`ifdef HT_HEAD_TABLE_INIT_EN
      state_q <= StInit;
`else
      state_q <= StRun;
`endif
      init_cnt_q <= '0;
    end else if (state_q == StInit) begin
      init_cnt_q <= init_cnt_q + BUCKET_WIDTH'(1);
      if (init_cnt_q == '1) begin
        state_q <= StRun;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q       <= 1'b0;
      s1_fresh_q       <= 1'b0;
      s1_hold_q        <= '0;
      s1_key_q         <= '0;
      s1_value_q       <= '0;
      s1_opcode_q      <= '0;
      s1_bucket_q      <= '0;
      out_valid        <= 1'b0;
      out_key          <= '0;
      out_value        <= '0;
      out_opcode       <= '0;
      out_bucket       <= '0;
      out_head_ptr     <= '0;
      out_head_ptr_val <= 1'b0;
    end else begin
      if (out_adv) begin
        out_valid <= s1_valid_q;
        if (s1_valid_q) begin
          out_key          <= s1_key_q;
          out_value        <= s1_value_q;
          out_opcode       <= s1_opcode_q;
          out_bucket       <= s1_bucket_q;
          out_head_ptr     <= s1_patched[HEAD_PTR_WIDTH-1:0];
          out_head_ptr_val <= s1_patched[HEAD_PTR_WIDTH];
        end
      end

      if (acc) begin
        s1_valid_q  <= 1'b1;
        s1_fresh_q  <= 1'b1;
        s1_key_q    <= in_key;
        s1_value_q  <= in_value;
        s1_opcode_q <= in_opcode;
        s1_bucket_q <= in_bucket;
      end else if (s1_valid_q && out_adv) begin
        s1_valid_q <= 1'b0;
      end else if (s1_valid_q) begin
        s1_hold_q  <= s1_patched;
        s1_fresh_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ht_head_table.sv
// Scoreboard bench for ht_head_table: directed commands push expectations, a monitor pops them.
module tb_ht_head_table;

  localparam int unsigned KW = 32;
  localparam int unsigned VW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned PW = 8;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] value;
    logic [1:0]    op;
    logic [BW-1:0] bucket;
    logic [PW-1:0] ptr;
    logic          pval;
  } item_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [KW-1:0] in_key;
  logic [VW-1:0] in_value;
  logic [1:0]    in_opcode;
  logic [BW-1:0] in_bucket;
  logic          in_valid;
  logic          in_ready;
  logic [KW-1:0] out_key;
  logic [VW-1:0] out_value;
  logic [1:0]    out_opcode;
  logic [BW-1:0] out_bucket;
  logic [PW-1:0] out_head_ptr;
  logic          out_head_ptr_val;
  logic          out_valid;
  logic          out_ready;
  logic          upd_valid;
  logic [BW-1:0] upd_bucket;
  logic [PW-1:0] upd_head_ptr;
  logic          upd_head_ptr_val;

  item_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  ht_head_table #(
    .KEY_WIDTH     (KW),
    .VALUE_WIDTH   (VW),
    .BUCKET_WIDTH  (BW),
    .HEAD_PTR_WIDTH(PW),
    .ht_opcode_t   (logic [1:0])
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .in_key          (in_key),
    .in_value        (in_value),
    .in_opcode       (in_opcode),
    .in_bucket       (in_bucket),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_key         (out_key),
    .out_value       (out_value),
    .out_opcode      (out_opcode),
    .out_bucket      (out_bucket),
    .out_head_ptr    (out_head_ptr),
    .out_head_ptr_val(out_head_ptr_val),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .upd_valid       (upd_valid),
    .upd_bucket      (upd_bucket),
    .upd_head_ptr    (upd_head_ptr),
    .upd_head_ptr_val(upd_head_ptr_val)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input logic [BW-1:0] b, input logic [PW-1:0] p, input logic v);
    upd_valid        = 1'b1;
    upd_bucket       = b;
    upd_head_ptr     = p;
    upd_head_ptr_val = v;
    tick();
    upd_valid = 1'b0;
  endtask

  // Offers one command, waits (bounded) for acceptance and records the hand-computed result.
  task automatic send(input logic [BW-1:0] b, input logic [KW-1:0] k, input logic [1:0] op,
                      input logic [PW-1:0] p, input logic v);
    item_t e;
    bit    done;
    done      = 1'b0;
    in_bucket = b;
    in_key    = k;
    in_value  = ~k;
    in_opcode = op;
    in_valid  = 1'b1;
    e = '{key: k, value: ~k, op: op, bucket: b, ptr: p, pval: v};
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    upd_valid = 1'b0;
    if (done) begin
      sb.push_back(e);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  // Every visible output must match the oldest outstanding expectation, stalled or not.
  always @(negedge clk_i) begin
    item_t act;
    if (!rst_i && out_valid) begin
      act = '{key: out_key, value: out_value, op: out_opcode, bucket: out_bucket,
              ptr: out_head_ptr, pval: out_head_ptr_val};
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got %h, expected no output", act);
      end else begin
        if (act !== sb[0]) begin
          n_err++;
          $display("FAIL out_item: got %h, expected %h", act, sb[0]);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int cnt;
    int stale;
    in_valid         = 1'b0;
    in_key           = '0;
    in_value         = '0;
    in_opcode        = '0;
    in_bucket        = '0;
    out_ready        = 1'b1;
    upd_valid        = 1'b0;
    upd_bucket       = '0;
    upd_head_ptr     = '0;
    upd_head_ptr_val = 1'b0;
    rst_i            = 1'b1;

    @(negedge clk_i);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_key", 64'(out_key), 64'd0);
    check("rst_out_head_ptr", 64'({out_head_ptr_val, out_head_ptr}), 64'd0);
    tick();
    rst_i = 1'b0;

`ifdef HT_HEAD_TABLE_INIT_EN
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (in_ready) break;
      cnt++;
    end
    check("init_cycles", 64'(cnt), 64'd16);
    tick();
    send(4'd9, 32'h0, 2'd0, 8'h00, 1'b0);
`else
    @(negedge clk_i);
    check("run_after_reset", 64'(in_ready), 64'd1);
    tick();
    for (int b = 0; b < 16; b++) upd(4'(b), 8'h00, 1'b0);
`endif

    // Update then read, with latency check.
    repeat (3) tick();
    upd(4'd5, 8'h2A, 1'b1);
    send(4'd5, 32'h1234, 2'd1, 8'h2A, 1'b1);
    @(negedge clk_i);
    check("lat_t1_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk_i);
    check("lat_t2_out_valid", 64'(out_valid), 64'd1);
    tick();

    // Same-cycle write-first bypass.
    repeat (3) tick();
    upd_valid        = 1'b1;
    upd_bucket       = 4'd3;
    upd_head_ptr     = 8'h11;
    upd_head_ptr_val = 1'b1;
    send(4'd3, 32'hBEEF, 2'd2, 8'h11, 1'b1);

    // S1 patch while stalled; OUT keeps its value despite a write to its bucket.
    upd(4'd6, 8'h66, 1'b1);
    upd(4'd7, 8'h77, 1'b1);
    repeat (3) tick();
    out_ready = 1'b0;
    send(4'd6, 32'h600D, 2'd0, 8'h66, 1'b1);
    send(4'd7, 32'h7777, 2'd3, 8'h5C, 1'b0);
    repeat (2) tick();
    @(negedge clk_i);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    tick();
    upd(4'd6, 8'h99, 1'b1);
    upd(4'd7, 8'h5C, 1'b0);
    repeat (2) tick();
    out_ready = 1'b1;
    repeat (4) tick();
    check("patch_drained", 64'(sb.size()), 64'd0);

    // Backpressure stream with out_ready pattern 1,0,0,1.
    for (int i = 0; i < 8; i++) upd(4'(8 + i), 8'(8'h80 + i), 1'b1);
    fork
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = ((c % 4) == 0) || ((c % 4) == 3);
          tick();
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) send(4'(8 + i), 32'(32'hA000 + i), 2'(i), 8'(8'h80 + i), 1'b1);
      end
    join
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    check("stream_drained", 64'(sb.size()), 64'd0);

    // Reset with two items in flight.
    out_ready = 1'b0;
    send(4'd5, 32'h5555, 2'd1, 8'h2A, 1'b1);
    send(4'd3, 32'h3333, 2'd2, 8'h11, 1'b1);
    tick();
    rst_i = 1'b1;
    sb.delete();
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    repeat (2) tick();
    rst_i     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (in_ready) break;
    end
    check("ready_after_rst", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (out_valid) stale++;
    end
    check("no_stale_items", 64'(stale), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ht_head_table.md
Name: ht_head_table

Overview:
- Stage between the hash calculator and the data-table engine.
- Takes commands that already carry a bucket index (key, value, opcode, bucket).
- Reads the per-bucket head pointer from a 2^BUCKET_WIDTH-entry RAM and emits the command with head_ptr/head_ptr_val filled in, in ht_if master form.
- Head-pointer updates produced by the data-table engine after insert/delete are written back through a dedicated update port.

Parameters:
KEY_WIDTH, hash_table::KEY_WIDTH, key field width
VALUE_WIDTH, hash_table::VALUE_WIDTH, value field width
BUCKET_WIDTH, hash_table::BUCKET_WIDTH, bucket index width; table depth 2^BUCKET_WIDTH
HEAD_PTR_WIDTH, hash_table::HEAD_PTR_WIDTH, head pointer width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
in_key  in  KEY_WIDTH  command key
in_value  in  VALUE_WIDTH  command value
in_opcode  in  ht_opcode_t  command opcode
in_bucket  in  BUCKET_WIDTH  bucket from hash stage
in_valid  in  1  command valid
in_ready  out  1  command accepted when in_valid&&in_ready
out_key  out  KEY_WIDTH  passed key
out_value  out  VALUE_WIDTH  passed value
out_opcode  out  ht_opcode_t  passed opcode
out_bucket  out  BUCKET_WIDTH  passed bucket
out_head_ptr  out  HEAD_PTR_WIDTH  head pointer of bucket
out_head_ptr_val  out  1  bucket non-empty
out_valid  out  1  output valid
out_ready  in  1  downstream ready
upd_valid  in  1  head-table write strobe
upd_bucket  in  BUCKET_WIDTH  bucket to write
upd_head_ptr  in  HEAD_PTR_WIDTH  new head pointer
upd_head_ptr_val  in  1  new valid flag (0 = bucket emptied)

Behaviour:
- Reset (asynchronous): out_valid=0, in_ready=0; all out_* data fields = 0; internal stage valids cleared; state = INIT (macro on) or RUN (macro off).
- RAM: single write port and single read port; 1-cycle registered read; entry = {head_ptr_val, head_ptr}.
- Pipeline, two internal slots:
  - S1 = read in flight / held result.
  - OUT = output register.
- Latency: command accepted at cycle T appears on out_* at T+2 when unstalled. Throughput is 1 per cycle.
- Handshake:
  - in_ready = RUN && !(S1_valid && out_valid && !out_ready).
  - out_* fields remain stable while out_valid && !out_ready.
  - No drop, duplication or reordering.
- S1 advance: if OUT is empty or draining, S1 loads OUT. Otherwise S1 holds and latches the RAM q into its hold register, so the RAM may be re-addressed.
- Write/read collisions:
  - upd_valid at T with upd_bucket == in_bucket of a command accepted at T: the command receives the written value (write-first bypass).
  - upd_valid matching the bucket held in S1: the S1 data is patched with the written value.
  - The OUT register is never patched.
- Writes always complete in 1 cycle and are never back-pressured.
- Bucket and head_ptr arithmetic: none. Values pass through unmodified; bucket addresses the RAM directly, with no wrap logic needed.

Optional Feature:
- Macro HT_HEAD_TABLE_INIT_EN.
- Defined:
  - After reset, FSM INIT sweeps a counter 0..2^BUCKET_WIDTH-1, writing {0,0} to one entry per cycle.
  - in_ready=0 throughout INIT; upd_valid is ignored during INIT.
  - On the cycle after the last entry is written, FSM enters RUN (sweep takes 2^BUCKET_WIDTH cycles).
  - rst_i asserted mid-sweep restarts the sweep from 0.
- Undefined:
  - No sweep; FSM starts in RUN, so in_ready=1 on the first cycle after reset release.
  - RAM relies on a power-up initial value of all zeros.

Test Plan:
- Init (macro on, BUCKET_WIDTH=4): release reset -> in_ready=0 for 16 cycles, then 1; any bucket read returns head_ptr_val=0.
- Update then read: upd bucket=5, ptr=0x2A, val=1; one cycle later send SEARCH bucket=5 key=0x1234 -> out two cycles after accept with head_ptr=0x2A, head_ptr_val=1, key=0x1234.
- Same-cycle bypass: upd bucket=3, ptr=0x11 in the same cycle as accepting bucket=3 -> out_head_ptr=0x11, val=1.
- S1 patch: out_ready=0 with OUT and S1 holding (bucket 7 in S1); upd bucket=7, val=0 -> after releasing out_ready, S1 item emerges with head_ptr_val=0. OUT item is unchanged.
- Backpressure: stream 8 commands with out_ready toggling 1,0,0,1… -> all 8 emerge in order with no duplicates; in_ready drops only while both slots are full and stalled.
- Reset mid-traffic: assert rst_i with 2 items in flight -> out_valid=0 immediately; after release no stale item is emitted.
